pipe_perf_monitor: RTL and testbench
====================================

Name: pipe_perf_monitor

Overview:
- Synthesizable, parametrised run-time monitor for the 5-stage RISC-V datapath.
- Watches the IF-stage PC/instruction stream and the hazard-unit stall flag.
- Counts cycles, retired instructions and stalls; detects halt loops of period 1..MAX_PERIOD and a cycle timeout.
- Freezes its statistics on the first detected end condition so the SoC bus or a bench can read them in place of ad-hoc testbench counters.

Parameters:
- XLEN, 32: PC/instruction width.
- CNT_W, 32: width of every counter.
- MAX_PERIOD, 4: longest loop period detected (1..8). PC history depth = MAX_PERIOD.
- STABLE_THRESH, 3: period-1 match count that declares halt.
- LOOP_MULT, 2: period-p threshold = LOOP_MULT*p, for p >= 2.
- TIMEOUT_CYCLES, 2000: cycle_count value that declares timeout. 0 disables timeout.
- NOP_INSN, 32'h00000013: instruction word never counted as retired.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  sample the stream this cycle.
- clear  in  1  synchronous restart of the monitor; same effect as reset.
- pc  in  XLEN  current fetch PC.
- instr  in  XLEN  current fetched instruction.
- stall  in  1  pipeline stall flag.
- cycle_count  out  CNT_W  enabled cycles sampled in RUN.
- instr_count  out  CNT_W  retired instructions.
- stall_count  out  CNT_W  stalled cycles.
- halt_detected  out  1  loop detected; sticky.
- halt_period  out  4  period of the detected loop; 0 if none.
- halt_pc  out  XLEN  PC sampled at the detecting edge.
- timeout  out  1  TIMEOUT_CYCLES reached without a halt; sticky.
- done  out  1  halt_detected | timeout.

Behaviour:
- Reset (reset=0 at an edge) and clear=1 have identical effect:
  - state=RUN; all counters, match counters, history valid count, halt_period and halt_pc = 0.
  - halt_detected, timeout, done = 0.
  - reset has priority over clear and over every other input. Asserting either mid-run or after halt restarts cleanly.
- States: RUN, HALTED, TIMEDOUT.
  - HALTED and TIMEDOUT are terminal until reset or clear.
  - In terminal states, counters and history are frozen and inputs are ignored.
- In RUN with enable=1, at each edge:
  - cycle_count += 1.
  - stall_count += 1 if stall=1.
  - instr_count += 1 if stall=0 and instr != NOP_INSN.
  - All counters saturate at all-ones.
  - enable=0: no state changes at all.
- PC history hist[0..MAX_PERIOD-1]: hist[0] = PC of the previous sample, hist[k] = PC sampled k+1 samples ago. prev_instr holds the previous instruction. Shifts once per sample.
- Period-1 match counter m1:
  - Increments when pc==hist[0] and instr==prev_instr, with at least 1 valid history sample; otherwise clears to 0.
  - Fires when the updated m1 == STABLE_THRESH.
- Period-p match counter mp, for p >= 2:
  - Increments when pc==hist[p-1] with at least p valid history samples; otherwise clears.
  - Fires when the updated mp == LOOP_MULT*p.
- All match counters update in parallel on the same sample.
- On a firing edge:
  - state <- HALTED; halt_detected = 1 from the next cycle.
  - halt_period = smallest firing p; lower period wins on a simultaneous fire.
  - halt_pc = pc of that sample.
  - The firing sample is itself counted in cycle_count and instr_count.
- Timeout: in RUN, if the updated cycle_count == TIMEOUT_CYCLES and no period fires on that sample, state <- TIMEDOUT and timeout=1. If a halt fires on the same edge, halt wins and timeout stays 0.
- Sample of the halt edge for a loop of period p: sample index p + LOOP_MULT*p, 1-based, from the first loop sample. Period 1 halts on its (STABLE_THRESH+1)th identical sample.
- Outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: PERFMON_CPI_EN.
- Defined adds ports cpi (out, 16, unsigned Q8.8 = cycle_count*256/instr_count) and cpi_valid (out, 1).
- CPI is computed by a restoring serial divider:
  - Starts on the edge entering HALTED or TIMEDOUT.
  - Takes CNT_W+8 cycles; cpi_valid rises the cycle after the last iteration and stays high.
  - Quotient > 0xFFFF saturates to 0xFFFF.
  - instr_count = 0 gives cpi = 0 with cpi_valid after the same latency.
  - reset or clear aborts the divider; cpi = 0 and cpi_valid = 0.
- Undefined: no divider logic and no cpi or cpi_valid ports.

Test Plan:
- Single-instruction loop: 5 distinct PCs, then pc=0x28 / instr=0x0000006F held. done rises after the 4th 0x28 sample; halt_period=1, halt_pc=0x28, cycle_count=9.
- Two-instruction loop: PCs alternate 0x30, 0x34 from cycle 1. Halt at sample 6; halt_period=2, halt_pc=0x34; no period-1 fire.
- Stall and NOP accounting: 10 samples, 3 with stall=1 and 2 NOPs among the unstalled ones, no loop. cycle_count=10, stall_count=3, instr_count=5.
- Timeout: TIMEOUT_CYCLES=50, monotonically increasing PCs. timeout=1 after sample 50, halt_detected=0, counters frozen when fed further input.
- Reset and clear: reset=0 for one edge mid-run at cycle 20; all outputs 0 next cycle. Then clear=1 after halt; state returns to RUN and a new period-3 loop halts at sample 9.
- PERFMON_CPI_EN: 100 cycles with 80 retired, then halt. cpi=0x0140 with cpi_valid CNT_W+8 cycles after the halt edge. Repeat with instr_count=0: cpi=0.

Source files
------------

// File: rtl/pipe_perf_monitor_if.sv
// Monitor-facing bus: sampled pipeline stream in, frozen statistics out.
// PERFMON_CPI_EN adds the cpi/cpi_valid result signals.
interface pipe_perf_monitor_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             enable;
  logic             clear;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  instr;
  logic             stall;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] stall_count;
  logic             halt_detected;
  logic [3:0]       halt_period;
  logic [XLEN-1:0]  halt_pc;
  logic             timeout;
  logic             done;

`ifdef PERFMON_CPI_EN
  logic [15:0]      cpi;
  logic             cpi_valid;

  modport master (
    output enable, clear, pc, instr, stall,
    input  cycle_count, instr_count, stall_count, halt_detected, halt_period,
           halt_pc, timeout, done, cpi, cpi_valid
  );
  modport slave (
    input  enable, clear, pc, instr, stall,
    output cycle_count, instr_count, stall_count, halt_detected, halt_period,
           halt_pc, timeout, done, cpi, cpi_valid
  );
`else
  modport master (
    output enable, clear, pc, instr, stall,
    input  cycle_count, instr_count, stall_count, halt_detected, halt_period,
           halt_pc, timeout, done
  );
  modport slave (
    input  enable, clear, pc, instr, stall,
    output cycle_count, instr_count, stall_count, halt_detected, halt_period,
           halt_pc, timeout, done
  );
`endif
endinterface

// File: rtl/pipe_perf_monitor.sv
// Run-time pipeline monitor: cycle/retire/stall counters, halt-loop and timeout detection.
// Optional Q8.8 CPI serial divider enabled by defining PERFMON_CPI_EN.
module pipe_perf_monitor #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     CNT_W          = 32,
  parameter int unsigned     MAX_PERIOD     = 4,
  parameter int unsigned     STABLE_THRESH  = 3,
  parameter int unsigned     LOOP_MULT      = 2,
  parameter int unsigned     TIMEOUT_CYCLES = 2000,
  parameter logic [XLEN-1:0] NOP_INSN       = XLEN'(32'h00000013)
) (
  input logic                clock,
  input logic                reset,
  pipe_perf_monitor_if.slave mon
);

  localparam int unsigned LOOP_MAX = LOOP_MULT * MAX_PERIOD;
  localparam int unsigned THR_MAX  = (STABLE_THRESH > LOOP_MAX) ? STABLE_THRESH : LOOP_MAX;
  localparam int unsigned M_W      = $clog2(THR_MAX + 1);
  localparam int unsigned HV_W     = $clog2(MAX_PERIOD + 1);

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_TIMEDOUT} state_e;

  function automatic int unsigned thr_of(int unsigned p);
    return (p == 1) ? STABLE_THRESH : LOOP_MULT * p;
  endfunction

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   cycle_q, cycle_d;
  logic [CNT_W-1:0]                   instr_q, instr_d;
  logic [CNT_W-1:0]                   stall_q, stall_d;
  logic [MAX_PERIOD-1:0][XLEN-1:0]    hist_q, hist_d;
  logic [XLEN-1:0]                    prev_instr_q, prev_instr_d;
  logic [HV_W-1:0]                    hvalid_q, hvalid_d;
  logic [MAX_PERIOD-1:0][M_W-1:0]     match_q, match_d;
  logic                               halt_q, halt_d;
  logic [3:0]                         period_q, period_d;
  logic [XLEN-1:0]                    hpc_q, hpc_d;
  logic                               timeout_q, timeout_d;
  logic                               done_q, done_d;

  // Sampling, loop matching and end-condition FSM.
  always_comb begin
    logic       hit;
    logic       fire;
    logic [3:0] fire_p;
    state_d      = state_q;
    cycle_d      = cycle_q;
    instr_d      = instr_q;
    stall_d      = stall_q;
    hist_d       = hist_q;
    prev_instr_d = prev_instr_q;
    hvalid_d     = hvalid_q;
    match_d      = match_q;
    halt_d       = halt_q;
    period_d     = period_q;
    hpc_d        = hpc_q;
    timeout_d    = timeout_q;
    done_d       = done_q;
    hit          = 1'b0;
    fire         = 1'b0;
    fire_p       = 4'd0;

    if (state_q == ST_RUN && mon.enable) begin
      if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
      if (mon.stall) begin
        if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
      end else if (mon.instr != NOP_INSN) begin
        if (instr_q != '1) instr_d = instr_q + CNT_W'(1);
      end

      // Lowest period is evaluated first so it wins a simultaneous fire.
      for (int unsigned p = 1; p <= MAX_PERIOD; p++) begin
        hit = (32'(hvalid_q) >= p) && (mon.pc == hist_q[p-1]);
        if (p == 1) hit = hit && (mon.instr == prev_instr_q);
        if (!hit) begin
          match_d[p-1] = '0;
        end else if (match_q[p-1] != '1) begin
          match_d[p-1] = match_q[p-1] + M_W'(1);
        end
        if (!fire && hit && (32'(match_d[p-1]) == thr_of(p))) begin
          fire   = 1'b1;
          fire_p = 4'(p);
        end
      end

      hist_d[0] = mon.pc;
      for (int unsigned k = 1; k < MAX_PERIOD; k++) hist_d[k] = hist_q[k-1];
      prev_instr_d = mon.instr;
      if (32'(hvalid_q) < MAX_PERIOD) hvalid_d = hvalid_q + HV_W'(1);

      if (fire) begin
        state_d  = ST_HALTED;
        halt_d   = 1'b1;
        period_d = fire_p;
        hpc_d    = mon.pc;
        done_d   = 1'b1;
      end else if (TIMEOUT_CYCLES != 0 && cycle_d == CNT_W'(TIMEOUT_CYCLES)) begin
        state_d   = ST_TIMEDOUT;
        timeout_d = 1'b1;
        done_d    = 1'b1;
      end
    end

    if (mon.clear) begin
      state_d      = ST_RUN;
      cycle_d      = '0;
      instr_d      = '0;
      stall_d      = '0;
      hist_d       = '0;
      prev_instr_d = '0;
      hvalid_d     = '0;
      match_d      = '0;
      halt_d       = 1'b0;
      period_d     = 4'd0;
      hpc_d        = '0;
      timeout_d    = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      cycle_q      <= '0;
      instr_q      <= '0;
      stall_q      <= '0;
      hist_q       <= '0;
      prev_instr_q <= '0;
      hvalid_q     <= '0;
      match_q      <= '0;
      halt_q       <= 1'b0;
      period_q     <= 4'd0;
      hpc_q        <= '0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      instr_q      <= instr_d;
      stall_q      <= stall_d;
      hist_q       <= hist_d;
      prev_instr_q <= prev_instr_d;
      hvalid_q     <= hvalid_d;
      match_q      <= match_d;
      halt_q       <= halt_d;
      period_q     <= period_d;
      hpc_q        <= hpc_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
    end
  end

  assign mon.cycle_count   = cycle_q;
  assign mon.instr_count   = instr_q;
  assign mon.stall_count   = stall_q;
  assign mon.halt_detected = halt_q;
  assign mon.halt_period   = period_q;
  assign mon.halt_pc       = hpc_q;
  assign mon.timeout       = timeout_q;
  assign mon.done          = done_q;

`ifdef PERFMON_CPI_EN
  localparam int unsigned QW   = CNT_W + 8;
  localparam int unsigned DC_W = $clog2(QW + 1);

  logic             busy_q, busy_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic [QW-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] den_q, den_d;
  logic [15:0]      cpi_q, cpi_d;
  logic             cpi_valid_q, cpi_valid_d;

  // Restoring divider: (cycle_count << 8) / instr_count, one quotient bit per cycle.
  always_comb begin
    logic [CNT_W:0] trial;
    busy_d      = busy_q;
    dcnt_d      = dcnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    den_d       = den_q;
    cpi_d       = cpi_q;
    cpi_valid_d = cpi_valid_q;
    trial       = {rem_q, quo_q[QW-1]};

    if (mon.clear) begin
      busy_d      = 1'b0;
      dcnt_d      = '0;
      quo_d       = '0;
      rem_d       = '0;
      den_d       = '0;
      cpi_d       = 16'd0;
      cpi_valid_d = 1'b0;
    end else if (state_q == ST_RUN && state_d != ST_RUN) begin
      busy_d = 1'b1;
      dcnt_d = '0;
      quo_d  = {cycle_d, 8'd0};
      rem_d  = '0;
      den_d  = instr_d;
    end else if (busy_q) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d = CNT_W'(trial - {1'b0, den_q});
        quo_d = {quo_q[QW-2:0], 1'b1};
      end else begin
        rem_d = trial[CNT_W-1:0];
        quo_d = {quo_q[QW-2:0], 1'b0};
      end
      dcnt_d = dcnt_q + DC_W'(1);
      if (32'(dcnt_q) == QW - 1) begin
        busy_d      = 1'b0;
        cpi_valid_d = 1'b1;
        if (den_q == '0)          cpi_d = 16'd0;
        else if (|quo_d[QW-1:16]) cpi_d = 16'hFFFF;
        else                      cpi_d = quo_d[15:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q      <= 1'b0;
      dcnt_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      den_q       <= '0;
      cpi_q       <= 16'd0;
      cpi_valid_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      dcnt_q      <= dcnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      den_q       <= den_d;
      cpi_q       <= cpi_d;
      cpi_valid_q <= cpi_valid_d;
    end
  end

  assign mon.cpi       = cpi_q;
  assign mon.cpi_valid = cpi_valid_q;
`endif

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: directed scenarios plus random streams against a sample-log model.
// Two DUTs share the stimulus: default timeout (2000) and a short timeout (50).
module tb_pipe_perf_monitor;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned DIV_N = CNT_W + 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clock = ~clock;

  pipe_perf_monitor_if #(.XLEN(32), .CNT_W(32)) bus ();
  pipe_perf_monitor_if #(.XLEN(32), .CNT_W(32)) bus_to ();

  pipe_perf_monitor dut (.clock(clock), .reset(reset), .mon(bus));
  pipe_perf_monitor #(.TIMEOUT_CYCLES(50)) dut_to (.clock(clock), .reset(reset), .mon(bus_to));

  // Reference model: per-DUT end state plus a shared log of samples since restart.
  int          m_state [2];
  logic [31:0] m_cyc [2], m_ins [2], m_stl [2], m_hpc [2];
  logic [3:0]  m_hper [2];
  logic        m_halt [2], m_to [2];
  logic [15:0] m_cpi [2], m_pend [2];
  logic        m_cpiv [2], m_busy [2];
  int          m_dcnt [2];
  logic [31:0] log_pc [$];
  logic [31:0] log_in [$];

  function automatic int unsigned to_lim(int k);
    return (k == 0) ? 2000 : 50;
  endfunction

  function automatic void m_zero(int k);
    m_state[k] = 0; m_cyc[k] = 0; m_ins[k] = 0; m_stl[k] = 0; m_hpc[k] = 0;
    m_hper[k] = 0; m_halt[k] = 0; m_to[k] = 0; m_cpi[k] = 0; m_pend[k] = 0;
    m_cpiv[k] = 0; m_busy[k] = 0; m_dcnt[k] = 0;
  endfunction

  // Number of consecutive most-recent samples that repeat the sample p positions earlier.
  function automatic int run_len(int p, logic [31:0] pc, logic [31:0] in);
    int r = 0;
    int n = log_pc.size();
    for (int t = n; t - p >= 0; t--) begin
      logic [31:0] pt, it;
      pt = (t == n) ? pc : log_pc[t];
      it = (t == n) ? in : log_in[t];
      if (pt != log_pc[t-p]) break;
      if (p == 1 && it != log_in[t-1]) break;
      r++;
      if (r > 64) break;
    end
    return r;
  endfunction

  function automatic void model_edge(logic r, logic e, logic c, logic [31:0] pc,
                                     logic [31:0] in, logic s);
    int fp = 0;
    for (int p = 1; p <= 4; p++) begin
      int thr = (p == 1) ? 3 : 2 * p;
      if (fp == 0 && run_len(p, pc, in) == thr) fp = p;
    end
    for (int k = 0; k < 2; k++) begin
      if (!r || c) begin
        m_zero(k);
        continue;
      end
      if (m_busy[k]) begin
        m_dcnt[k]++;
        if (m_dcnt[k] == DIV_N) begin
          m_busy[k] = 0; m_cpiv[k] = 1; m_cpi[k] = m_pend[k];
        end
      end
      if (m_state[k] == 0 && e) begin
        if (m_cyc[k] != '1) m_cyc[k]++;
        if (s) begin
          if (m_stl[k] != '1) m_stl[k]++;
        end else if (in != NOP) begin
          if (m_ins[k] != '1) m_ins[k]++;
        end
        if (fp != 0) begin
          m_state[k] = 1; m_halt[k] = 1; m_hper[k] = 4'(fp); m_hpc[k] = pc;
        end else if (to_lim(k) != 0 && m_cyc[k] == to_lim(k)) begin
          m_state[k] = 2; m_to[k] = 1;
        end
        if (m_state[k] != 0) begin
          logic [63:0] q;
          q = (m_ins[k] == 0) ? 64'd0 : ({32'd0, m_cyc[k]} * 64'd256) / {32'd0, m_ins[k]};
          m_pend[k] = (q > 64'hFFFF) ? 16'hFFFF : q[15:0];
          m_busy[k] = 1; m_dcnt[k] = 0;
        end
      end
    end
    if (!r || c) begin
      log_pc.delete(); log_in.delete();
    end else if (e) begin
      log_pc.push_back(pc); log_in.push_back(in);
      if (log_pc.size() > 64) begin
        void'(log_pc.pop_front()); void'(log_in.pop_front());
      end
    end
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_dut(int k);
    string sfx = (k == 0) ? "main" : "to50";
    check({"cycle_count.", sfx},   64'(k == 0 ? bus.cycle_count   : bus_to.cycle_count),   64'(m_cyc[k]));
    check({"instr_count.", sfx},   64'(k == 0 ? bus.instr_count   : bus_to.instr_count),   64'(m_ins[k]));
    check({"stall_count.", sfx},   64'(k == 0 ? bus.stall_count   : bus_to.stall_count),   64'(m_stl[k]));
    check({"halt_detected.", sfx}, 64'(k == 0 ? bus.halt_detected : bus_to.halt_detected), 64'(m_halt[k]));
    check({"halt_period.", sfx},   64'(k == 0 ? bus.halt_period   : bus_to.halt_period),   64'(m_hper[k]));
    check({"halt_pc.", sfx},       64'(k == 0 ? bus.halt_pc       : bus_to.halt_pc),       64'(m_hpc[k]));
    check({"timeout.", sfx},       64'(k == 0 ? bus.timeout       : bus_to.timeout),       64'(m_to[k]));
    check({"done.", sfx},          64'(k == 0 ? bus.done          : bus_to.done),          64'(m_halt[k] | m_to[k]));
`ifdef PERFMON_CPI_EN
    check({"cpi.", sfx},           64'(k == 0 ? bus.cpi           : bus_to.cpi),           64'(m_cpi[k]));
    check({"cpi_valid.", sfx},     64'(k == 0 ? bus.cpi_valid     : bus_to.cpi_valid),     64'(m_cpiv[k]));
`endif
  endtask

  task automatic step(logic r, logic e, logic c, logic [31:0] pc, logic [31:0] in, logic s);
    @(negedge clock);
    reset = r;
    bus.enable = e;    bus.clear = c;    bus.pc = pc;    bus.instr = in;    bus.stall = s;
    bus_to.enable = e; bus_to.clear = c; bus_to.pc = pc; bus_to.instr = in; bus_to.stall = s;
    @(posedge clock);
    model_edge(r, e, c, pc, in, s);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic samp(logic [31:0] pc, logic [31:0] in, logic s);
    step(1'b1, 1'b1, 1'b0, pc, in, s);
  endtask

  task automatic do_clear();
    step(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    bus.enable = 0; bus.clear = 0; bus.pc = 0; bus.instr = 0; bus.stall = 0;
    bus_to.enable = 0; bus_to.clear = 0; bus_to.pc = 0; bus_to.instr = 0; bus_to.stall = 0;

    // Reset state.
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.cycle_count", 64'(bus.cycle_count), 64'd0);

    // Single-instruction loop.
    for (int i = 0; i < 5; i++) samp(32'h14 + 32'(4 * i), 32'h00100093 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) samp(32'h28, 32'h0000006F, 1'b0);
    check("p1.done_before", 64'(bus.done), 64'd0);
    samp(32'h28, 32'h0000006F, 1'b0);
    check("p1.done", 64'(bus.done), 64'd1);
    check("p1.halt_period", 64'(bus.halt_period), 64'd1);
    check("p1.halt_pc", 64'(bus.halt_pc), 64'h28);
    check("p1.cycle_count", 64'(bus.cycle_count), 64'd9);
    samp(32'h99, 32'h1, 1'b1);
    check("p1.frozen", 64'(bus.cycle_count), 64'd9);

    // Two-instruction loop.
    do_clear();
    for (int i = 1; i <= 5; i++) samp((i % 2) ? 32'h30 : 32'h34, (i % 2) ? 32'h0040006F : 32'hFFDFF06F, 1'b0);
    check("p2.done_before", 64'(bus.done), 64'd0);
    samp(32'h34, 32'hFFDFF06F, 1'b0);
    check("p2.halt_period", 64'(bus.halt_period), 64'd2);
    check("p2.halt_pc", 64'(bus.halt_pc), 64'h34);

    // Stall and NOP accounting.
    do_clear();
    for (int i = 0; i < 10; i++)
      samp(32'h400 + 32'(4 * i), (i == 3 || i == 7) ? NOP : 32'h00208133, (i == 2 || i == 5 || i == 8));
    check("acct.cycle", 64'(bus.cycle_count), 64'd10);
    check("acct.stall", 64'(bus.stall_count), 64'd3);
    check("acct.instr", 64'(bus.instr_count), 64'd5);

    // Timeout on the short-timeout instance.
    do_clear();
    for (int i = 0; i < 49; i++) samp(32'h800 + 32'(4 * i), 32'h00000033, 1'b0);
    check("to.before", 64'(bus_to.timeout), 64'd0);
    samp(32'h800 + 32'(4 * 49), 32'h00000033, 1'b0);
    check("to.timeout", 64'(bus_to.timeout), 64'd1);
    check("to.halt", 64'(bus_to.halt_detected), 64'd0);
    for (int i = 50; i < 55; i++) samp(32'h800 + 32'(4 * i), 32'h00000033, 1'b1);
    check("to.frozen_cycle", 64'(bus_to.cycle_count), 64'd50);
    check("to.frozen_stall", 64'(bus_to.stall_count), 64'd0);

    // Mid-run reset, then clear after halt and a period-3 loop.
    do_clear();
    for (int i = 0; i < 19; i++) samp(32'hA00 + 32'(4 * i), 32'h00000033, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'hA50, 32'h33, 1'b0);
    check("rst.cycle", 64'(bus.cycle_count), 64'd0);
    check("rst.instr", 64'(bus.instr_count), 64'd0);
    for (int i = 0; i < 4; i++) samp(32'hB00, 32'h0000006F, 1'b0);
    check("rst.halted", 64'(bus.halt_detected), 64'd1);
    do_clear();
    check("clr.done", 64'(bus.done), 64'd0);
    check("clr.period", 64'(bus.halt_period), 64'd0);
    for (int i = 0; i < 8; i++) samp(32'h100 + 32'(4 * (i % 3)), 32'h00000033, 1'b0);
    check("p3.done_before", 64'(bus.done), 64'd0);
    samp(32'h108, 32'h00000033, 1'b0);
    check("p3.halt_period", 64'(bus.halt_period), 64'd3);
    check("p3.halt_pc", 64'(bus.halt_pc), 64'h108);

    // Random streams drawn from a small PC set so loops occur naturally.
    for (int run = 0; run < 8; run++) begin
      do_clear();
      for (int i = 0; i < 60; i++) begin
        int unsigned sel = $urandom_range(0, 99);
        int unsigned isel = $urandom_range(0, 2);
        logic [31:0] ins = (isel == 0) ? NOP : (isel == 1) ? 32'h0000006F : $urandom;
        step(sel != 0, $urandom_range(0, 9) != 0, sel == 1,
             32'h200 + 32'(4 * $urandom_range(0, 3)), ins, $urandom_range(0, 4) == 0);
      end
    end

`ifdef PERFMON_CPI_EN
    // CPI: 100 cycles, 80 retired.
    do_clear();
    for (int i = 0; i < 96; i++) samp(32'h1000 + 32'(4 * i), 32'h00000033, (i % 5) == 0);
    for (int i = 0; i < 4; i++) samp(32'h4000, 32'h0000006F, 1'b0);
    check("cpi.cycle", 64'(bus.cycle_count), 64'd100);
    check("cpi.instr", 64'(bus.instr_count), 64'd80);
    for (int i = 0; i < DIV_N - 1; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("cpi.valid_early", 64'(bus.cpi_valid), 64'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("cpi.valid", 64'(bus.cpi_valid), 64'd1);
    check("cpi.value", 64'(bus.cpi), 64'h0140);

    // CPI with nothing retired.
    do_clear();
    for (int i = 0; i < 4; i++) samp(32'h5000, 32'h0000006F, 1'b1);
    for (int i = 0; i < DIV_N; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("cpi0.valid", 64'(bus.cpi_valid), 64'd1);
    check("cpi0.value", 64'(bus.cpi), 64'd0);
    do_clear();
    check("cpi.clear", 64'(bus.cpi_valid), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
